// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 types and constants
// Holds the program-loader FSM state type, boot-frame layout constants, and the
// instruction codes used by the core.
package y86_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_t;

  // Boot frame: 2-byte little-endian length header, payload, 1-byte checksum.
  localparam int HDR_BYTES  = 2;
  localparam int CSUM_BYTES = 1;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

endpackage

// File: rtl/y86_prog_loader.sv
// rtl/y86_prog_loader.sv - boot-time program loader holding the core until a frame verifies
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   in_valid/in_data/in_ready byte stream in (transfer on in_valid && in_ready)
//   imem_we/imem_addr/imem_wdata registered instruction-memory byte write port
//   core_run                 core enable, high only after a verified frame
//   load_err                 sticky frame error
//   bytes_loaded             payload bytes written so far
module y86_prog_loader
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             imem_we,
  output logic [63:0]      imem_addr,
  output logic [7:0]       imem_wdata,
  output logic             core_run,
  output logic             load_err,
  output logic [LEN_W-1:0] bytes_loaded
);

  loader_state_t    state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       sum_q, sum_d;
  logic             we_q, we_d;
  logic [63:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;

  logic             xfer;
  logic [LEN_W-1:0] hdr_len;
  logic [LEN_W-1:0] cnt_inc;

  assign in_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                    (state_q == ST_DATA)   || (state_q == ST_CSUM);
  assign xfer     = in_valid && in_ready;

  // Full header length as it will look once the high byte lands.
  assign hdr_len  = LEN_W'({in_data, len_q[7:0]});
  assign cnt_inc  = cnt_q + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      ST_IDLE: state_d = ST_LEN_LO;
      ST_LEN_LO: begin
        if (xfer) begin
          len_d   = LEN_W'(in_data);
          state_d = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (xfer) begin
          len_d = hdr_len;
          // Widen both sides so MEM_BYTES = 2^LEN_W still compares correctly.
          if (32'(hdr_len) > 32'(MEM_BYTES)) begin
            state_d = ST_ERR;
          end else if (hdr_len == '0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          we_d    = 1'b1;
          addr_d  = 64'(cnt_q);
          wdata_d = in_data;
          cnt_d   = cnt_inc;
          sum_d   = sum_q + in_data;
          if (cnt_inc == len_q) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (xfer) begin
          state_d = (in_data == sum_q) ? ST_RUN : ST_ERR;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign core_run     = (state_q == ST_RUN);
  assign load_err     = (state_q == ST_ERR);
  assign bytes_loaded = cnt_q;

endmodule
